// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with a rename tag per register.
//   Decoder renames rd to a ROB entry (busy + tag). A ROB commit writes the
//   value and releases busy only if the committing entry is still the newest
//   producer. clear_all drops every in-flight rename. Two combinational read
//   ports forward a same-cycle commit so dispatch needs no bubble.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (low = hold all state)
//   rename_en/rename_rd/rename_rob_id      : decoder rename of rd
//   rs1_id/rs2_id -> rsN_busy/tag/value    : operand lookups
//   commit_en/commit_rd/commit_rob_id/commit_value : ROB commit write
//   clear_all                              : flush all renames
//   busy_count                             : registered number of busy regs

module regfile_rename_rdport #(
  parameter int REG_NUM       = 32,
  parameter int REG_ID_BIT    = 5,
  parameter int ROB_WIDTH_BIT = 4,
  parameter int XLEN          = 32
) (
  input  logic                                   i_rdy,
  input  logic                                   i_commit_en,
  input  logic [REG_ID_BIT-1:0]                  i_commit_rd,
  input  logic [ROB_WIDTH_BIT-1:0]               i_commit_rob_id,
  input  logic [XLEN-1:0]                        i_commit_value,
  input  logic [REG_ID_BIT-1:0]                  i_rs_id,
  input  logic [REG_NUM-1:0]                     i_busy,
  input  logic [REG_NUM-1:0][ROB_WIDTH_BIT-1:0]  i_tag,
  input  logic [REG_NUM-1:0][XLEN-1:0]           i_value,
  output logic                                   o_busy,
  output logic [ROB_WIDTH_BIT-1:0]               o_tag,
  output logic [XLEN-1:0]                        o_value
);
  logic w_fwd;

  // Forward only while the commit will actually land this edge.
  assign w_fwd = i_rdy && i_commit_en && (i_commit_rd == i_rs_id);

  always_comb begin
    o_busy  = 1'b0;
    o_tag   = '0;
    o_value = '0;
    if (i_rs_id != '0) begin
      o_busy  = i_busy[i_rs_id];
      o_tag   = i_tag[i_rs_id];
      o_value = i_value[i_rs_id];
      if (w_fwd) begin
        o_value = i_commit_value;
        // Only the newest producer's commit makes the operand ready.
        if (i_busy[i_rs_id] && (i_tag[i_rs_id] == i_commit_rob_id))
          o_busy = 1'b0;
      end
    end
  end
endmodule

module regfile_rename #(
  parameter int REG_NUM       = 32,
  parameter int REG_ID_BIT    = 5,
  parameter int ROB_WIDTH_BIT = 4,
  parameter int XLEN          = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     rename_en,
  input  logic [REG_ID_BIT-1:0]    rename_rd,
  input  logic [ROB_WIDTH_BIT-1:0] rename_rob_id,
  input  logic [REG_ID_BIT-1:0]    rs1_id,
  input  logic [REG_ID_BIT-1:0]    rs2_id,
  output logic                     rs1_busy,
  output logic [ROB_WIDTH_BIT-1:0] rs1_tag,
  output logic [XLEN-1:0]          rs1_value,
  output logic                     rs2_busy,
  output logic [ROB_WIDTH_BIT-1:0] rs2_tag,
  output logic [XLEN-1:0]          rs2_value,
  input  logic                     commit_en,
  input  logic [REG_ID_BIT-1:0]    commit_rd,
  input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
  input  logic [XLEN-1:0]          commit_value,
  input  logic                     clear_all,
  output logic [REG_ID_BIT:0]      busy_count
);
  localparam int NUM_PORTS = 2;

  logic [REG_NUM-1:0]                    r_busy;
  logic [REG_NUM-1:0][ROB_WIDTH_BIT-1:0] r_tag;
  logic [REG_NUM-1:0][XLEN-1:0]          r_value;
  logic [REG_ID_BIT:0]                   r_busy_count;

  logic [REG_NUM-1:0]                    w_busy_nxt;
  logic [REG_NUM-1:0][ROB_WIDTH_BIT-1:0] w_tag_nxt;
  logic [REG_ID_BIT:0]                   w_cnt_nxt;
  logic                                  w_commit_wr;
  logic                                  w_rename_wr;

  assign w_commit_wr = commit_en && (commit_rd != '0);
  assign w_rename_wr = rename_en && (rename_rd != '0) && !clear_all;

  // Priority: commit release, then rename (a younger producer wins), then
  // flush clears everything. Tags survive a flush untouched.
  always_comb begin
    w_busy_nxt = r_busy;
    w_tag_nxt  = r_tag;
    if (w_commit_wr && r_busy[commit_rd] && (r_tag[commit_rd] == commit_rob_id))
      w_busy_nxt[commit_rd] = 1'b0;
    if (w_rename_wr) begin
      w_busy_nxt[rename_rd] = 1'b1;
      w_tag_nxt[rename_rd]  = rename_rob_id;
    end
    if (clear_all)
      w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;
  end

  // busy_count tracks the post-edge busy vector so it is exact every cycle.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 1; i < REG_NUM; i++)
      w_cnt_nxt = w_cnt_nxt + (REG_ID_BIT+1)'(w_busy_nxt[i]);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy       <= '0;
      r_tag        <= '0;
      r_value      <= '0;
      r_busy_count <= '0;
    end else if (rdy_in) begin
      r_busy       <= w_busy_nxt;
      r_tag        <= w_tag_nxt;
      r_busy_count <= w_cnt_nxt;
      // Value is written even on a tag mismatch; busy still guards readers.
      if (w_commit_wr)
        r_value[commit_rd] <= commit_value;
    end
  end

  assign busy_count = r_busy_count;

  logic [NUM_PORTS-1:0][REG_ID_BIT-1:0]    w_rs_id;
  logic [NUM_PORTS-1:0]                    w_rd_busy;
  logic [NUM_PORTS-1:0][ROB_WIDTH_BIT-1:0] w_rd_tag;
  logic [NUM_PORTS-1:0][XLEN-1:0]          w_rd_value;

  assign w_rs_id = {rs2_id, rs1_id};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd
    regfile_rename_rdport #(
      .REG_NUM(REG_NUM), .REG_ID_BIT(REG_ID_BIT),
      .ROB_WIDTH_BIT(ROB_WIDTH_BIT), .XLEN(XLEN)
    ) u_rd (
      .i_rdy          (rdy_in),
      .i_commit_en    (commit_en),
      .i_commit_rd    (commit_rd),
      .i_commit_rob_id(commit_rob_id),
      .i_commit_value (commit_value),
      .i_rs_id        (w_rs_id[g]),
      .i_busy         (r_busy),
      .i_tag          (r_tag),
      .i_value        (r_value),
      .o_busy         (w_rd_busy[g]),
      .o_tag          (w_rd_tag[g]),
      .o_value        (w_rd_value[g])
    );
  end

  assign rs1_busy  = w_rd_busy[0];
  assign rs1_tag   = w_rd_tag[0];
  assign rs1_value = w_rd_value[0];
  assign rs2_busy  = w_rd_busy[1];
  assign rs2_tag   = w_rd_tag[1];
  assign rs2_value = w_rd_value[1];
endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Architectural register file with a per-register rename tag. It is the consumer end of the ROB commit interface and the responder to decoder operand lookups.
- Decoder renames rd to an allocated ROB entry. ROB commit writes the value and clears the busy bit when the tag still matches. Flush (clear_all) drops all in-flight renames.
- Read ports are combinational with same-cycle commit forwarding, so dispatch sees committed values without a bubble.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hardwired zero)
REG_ID_BIT, 5, width of register index
ROB_WIDTH_BIT, 4, width of ROB entry id (tag)
XLEN, 32, data width

Ports:
clk_in  input  1  clock, posedge
rst_in  input  1  reset, asynchronous, active-high
rdy_in  input  1  pause when low; no state change
rename_en  input  1  decoder issues instruction writing rd
rename_rd  input  REG_ID_BIT  destination register
rename_rob_id  input  ROB_WIDTH_BIT  ROB entry allocated to rd
rs1_id  input  REG_ID_BIT  lookup index 1
rs2_id  input  REG_ID_BIT  lookup index 2
rs1_busy  output  1  rs1 awaits an in-flight producer
rs1_tag  output  ROB_WIDTH_BIT  producer ROB id (valid when rs1_busy)
rs1_value  output  XLEN  register value (valid when !rs1_busy)
rs2_busy  output  1  as rs1
rs2_tag  output  ROB_WIDTH_BIT  as rs1
rs2_value  output  XLEN  as rs1
commit_en  input  1  ROB commit write
commit_rd  input  REG_ID_BIT  committed destination
commit_rob_id  input  ROB_WIDTH_BIT  committing ROB entry
commit_value  input  XLEN  committed result
clear_all  input  1  flush on misprediction
busy_count  output  REG_ID_BIT+1  registered count of busy registers

Behaviour:
- Reset (async, immediate): all values 0, busy 0, tags 0, busy_count 0. Outputs follow from this state via the combinational read path. Reset mid-operation discards all pending renames.
- rdy_in low: values, busy, tags and busy_count hold. Read ports stay combinational on the held state; forwarding is suppressed.
- x0: reads return busy=0, tag=0, value=0. Renames and commits to x0 are ignored and do not change busy_count.
- Commit at posedge (commit_en, rd!=0):
  - value[rd] <= commit_value, always.
  - busy[rd] cleared only if busy[rd] && tag[rd]==commit_rob_id. On tag mismatch (a younger rename exists), busy and tag are kept.
- Rename at posedge (rename_en, rd!=0, !clear_all): busy[rd] <= 1, tag[rd] <= rename_rob_id. A re-rename of an already-busy register overwrites the tag.
- Same rd commit+rename in one cycle: value is written; rename wins, so busy stays 1 with the new tag.
- clear_all at posedge: all busy cleared, tags unchanged, values kept. A same-cycle rename is dropped. A same-cycle commit value write still takes effect.
- Read path, combinational, per port, for rs!=0:
  - Default: busy[rs], tag[rs], value[rs].
  - If rdy_in && commit_en && commit_rd==rs: value = commit_value.
  - Additionally, if busy[rs] && tag[rs]==commit_rob_id: report busy=0.
  - Reads never see the same-cycle rename; the decoder handles its own rs==rd case.
- busy_count: updated each active edge to the number of busy registers after that edge's updates. Range 0..REG_NUM-1. It is 0 the edge after clear_all.
- Latency: rename and commit are visible on read ports the cycle after the edge. Commit is also visible the same cycle through forwarding.

Test Plan:
- Reset, then read x5 -> busy=0, value=0, busy_count=0. Assert rst_in between edges -> state clears immediately.
- Rename x5->ROB 3, next cycle read x5 -> busy=1, tag=3. Commit (x5, 3, 0xDEADBEEF) -> same-cycle read busy=0, value=0xDEADBEEF. Next cycle: busy=0, busy_count=0.
- Rename x7->ROB 2, then rename x7->ROB 6. Commit (x7, 2, 0x11) -> value=0x11, busy=1, tag=6. Commit (x7, 6, 0x22) -> busy=0, value=0x22.
- Same cycle: rename x9->ROB 4 and commit (x9, 1, 0x55) with prior tag 1 -> after edge value=0x55, busy=1, tag=4.
- Rename x1, x2, x3 (busy_count=3), then clear_all together with rename x4 -> all busy=0, busy_count=0, x4 not busy, values unchanged.
- Rename/commit to x0 -> reads stay 0, not busy. With rdy_in low, a commit to x5 -> no change and no forwarding.
